// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU opcode constants, datapath sizes and sequencer state encoding
package alu_pkg;
  localparam int WIDTH = 32;
  localparam int NREG = 8;
  localparam int OPW = 3;
  localparam logic [OPW-1:0] ALU_ADD = 3'b000;
  localparam logic [OPW-1:0] ALU_SUB = 3'b001;
  localparam logic [OPW-1:0] ALU_AND = 3'b010;
  localparam logic [OPW-1:0] ALU_OR = 3'b011;
  localparam logic [OPW-1:0] ALU_SRL = 3'b100;
  localparam logic [OPW-1:0] ALU_SRA = 3'b101;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
endpackage

// File: rtl/alu_regfile.sv
// alu_regfile: N x W register file; clk/rst_n, write port we/wa/wd, async read ports ra0->rd0 and ra1->rd1, r0 reads zero
module alu_regfile
  import alu_pkg::*;
#(
  parameter int W = WIDTH,
  parameter int N = NREG,
  parameter int AW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [W-1:0]  wd,
  input  logic [AW-1:0] ra0,
  input  logic [AW-1:0] ra1,
  output logic [W-1:0]  rd0,
  output logic [W-1:0]  rd1
);
  logic [W-1:0] mem [N];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      for (int i = 0; i < N; i++) mem[i] <= '0;
    else if (we && wa != '0)
      mem[wa] <= wd;
  assign rd0 = ra0 == '0 ? '0 : mem[ra0];
  assign rd1 = ra1 == '0 ? '0 : mem[ra1];
endmodule

// File: rtl/alu_seq.sv
// alu_seq: ALU sequencer; cmd_* valid/ready command in, alu_A/alu_B/alu_op out and alu_C in to an external ALU, rsp_* valid/ready result out
module alu_seq
  import alu_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [2:0]       cmd_rs,
  input  logic [2:0]       cmd_rt,
  input  logic [2:0]       cmd_rd,
  input  logic             cmd_use_imm,
  input  logic [15:0]      cmd_imm,
  output logic [WIDTH-1:0] alu_A,
  output logic [WIDTH-1:0] alu_B,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_C,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic [2:0]       rsp_rd,
  output logic             rsp_err
);
  state_t state;
  logic [WIDTH-1:0] ra_data, rb_data;
  assign cmd_ready = state == IDLE;
  alu_regfile u_rf (
    .clk(clk),
    .rst_n(rst_n),
    .we(state == EXEC),
    .wa(rsp_rd),
    .wd(alu_C),
    .ra0(cmd_rs),
    .ra1(cmd_rt),
    .rd0(ra_data),
    .rd1(rb_data)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      alu_A <= '0;
      alu_B <= '0;
      alu_op <= ALU_ADD;
      rsp_valid <= 1'b0;
      rsp_data <= '0;
      rsp_rd <= '0;
      rsp_err <= 1'b0;
    end else
      case (state)
        IDLE:
          if (cmd_valid) begin
            alu_A <= ra_data;
            alu_B <= cmd_use_imm ? {{(WIDTH-16){1'b0}}, cmd_imm} : rb_data;
            alu_op <= cmd_op;
            rsp_rd <= cmd_rd;
            rsp_err <= &cmd_op[2:1];
            state <= EXEC;
          end
        EXEC: begin
          rsp_data <= alu_C;
          rsp_valid <= 1'b1;
          state <= RESP;
        end
        RESP:
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state <= IDLE;
          end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed self-checking bench for alu_seq with a behavioural ALU stand-in
module tb_alu_seq;
  logic clk = 0, rst_n = 0;
  logic cmd_valid = 0, cmd_use_imm = 0, rsp_ready = 0;
  logic [2:0] cmd_op = 0, cmd_rs = 0, cmd_rt = 0, cmd_rd = 0;
  logic [15:0] cmd_imm = 0;
  logic cmd_ready, rsp_valid, rsp_err;
  logic [31:0] alu_A, alu_B, alu_C, rsp_data;
  logic [2:0] alu_op, rsp_rd;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  alu_seq dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_rs(cmd_rs), .cmd_rt(cmd_rt), .cmd_rd(cmd_rd),
    .cmd_use_imm(cmd_use_imm), .cmd_imm(cmd_imm), .alu_A(alu_A), .alu_B(alu_B),
    .alu_op(alu_op), .alu_C(alu_C), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_rd(rsp_rd), .rsp_err(rsp_err)
  );
  always_comb begin
    alu_C = '0;
    case (alu_op)
      3'b000: alu_C = alu_A + alu_B;
      3'b001: alu_C = alu_A - alu_B;
      3'b010: alu_C = alu_A & alu_B;
      3'b011: alu_C = alu_A | alu_B;
      3'b100: alu_C = alu_A >> alu_B;
      3'b101: alu_C = $unsigned($signed(alu_A) >>> alu_B);
      default: alu_C = '0;
    endcase
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic send(input logic [2:0] op, rs, rt, rd, input logic ui, input logic [15:0] imm);
    int w = 0;
    cmd_op = op; cmd_rs = rs; cmd_rt = rt; cmd_rd = rd; cmd_use_imm = ui; cmd_imm = imm;
    cmd_valid = 1;
    while (!cmd_ready && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    chk("accept_wait", w, 0);
    @(posedge clk); #1;
    cmd_valid = 0;
    chk("exec_rsp_valid", {31'b0, rsp_valid}, 0);
    chk("exec_cmd_ready", {31'b0, cmd_ready}, 0);
  endtask
  task automatic take(input logic [31:0] d, input logic [2:0] rd, input logic err);
    @(posedge clk); #1;
    chk("rsp_valid", {31'b0, rsp_valid}, 1);
    chk("rsp_data", rsp_data, d);
    chk("rsp_rd", {29'b0, rsp_rd}, {29'b0, rd});
    chk("rsp_err", {31'b0, rsp_err}, {31'b0, err});
    rsp_ready = 1;
    @(posedge clk); #1;
    rsp_ready = 0;
    chk("post_rsp_valid", {31'b0, rsp_valid}, 0);
    chk("post_cmd_ready", {31'b0, cmd_ready}, 1);
  endtask
  initial begin
    #1;
    chk("rst_cmd_ready", {31'b0, cmd_ready}, 1);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_rd", {29'b0, rsp_rd}, 0);
    chk("rst_rsp_err", {31'b0, rsp_err}, 0);
    chk("rst_alu_A", alu_A, 0);
    chk("rst_alu_B", alu_B, 0);
    chk("rst_alu_op", {29'b0, alu_op}, 0);
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;
    send(3'b000, 0, 0, 1, 1, 16'd5);      take(32'd5, 1, 0);
    send(3'b000, 0, 0, 2, 1, 16'hFFFF);   take(32'h0000_FFFF, 2, 0);
    send(3'b001, 1, 2, 3, 0, 16'h0);      take(32'hFFFF_0006, 3, 0);
    send(3'b001, 0, 0, 4, 1, 16'd1);      take(32'hFFFF_FFFF, 4, 0);
    send(3'b100, 4, 0, 4, 1, 16'd1);      take(32'h7FFF_FFFF, 4, 0);
    send(3'b000, 4, 0, 4, 1, 16'd1);      take(32'h8000_0000, 4, 0);
    send(3'b101, 4, 0, 6, 1, 16'd4);      take(32'hF800_0000, 6, 0);
    send(3'b100, 4, 0, 7, 1, 16'd4);      take(32'h0800_0000, 7, 0);
    send(3'b100, 4, 0, 6, 1, 16'd40);     take(32'h0, 6, 0);
    send(3'b101, 4, 0, 6, 1, 16'd40);     take(32'hFFFF_FFFF, 6, 0);
    send(3'b000, 0, 0, 5, 1, 16'd9);      take(32'd9, 5, 0);
    send(3'b110, 1, 0, 5, 0, 16'h0);      take(32'h0, 5, 1);
    send(3'b000, 5, 0, 6, 1, 16'd0);      take(32'h0, 6, 0);
    send(3'b111, 1, 2, 7, 1, 16'd3);      take(32'h0, 7, 1);
    send(3'b000, 0, 0, 1, 1, 16'h0F0F);   take(32'h0F0F, 1, 0);
    send(3'b000, 0, 0, 2, 1, 16'h00FF);   take(32'h00FF, 2, 0);
    send(3'b010, 1, 2, 3, 0, 16'h0);      take(32'h000F, 3, 0);
    send(3'b011, 1, 2, 3, 0, 16'h0);      take(32'h0FFF, 3, 0);
    send(3'b000, 0, 0, 0, 1, 16'd7);      take(32'd7, 0, 0);
    send(3'b011, 0, 1, 3, 0, 16'h0);      take(32'h0F0F, 3, 0);
    send(3'b000, 2, 0, 4, 1, 16'h0100);
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      chk("bp_rsp_valid", {31'b0, rsp_valid}, 1);
      chk("bp_rsp_data", rsp_data, 32'h01FF);
      chk("bp_rsp_rd", {29'b0, rsp_rd}, 4);
      chk("bp_cmd_ready", {31'b0, cmd_ready}, 0);
      @(posedge clk); #1;
    end
    rsp_ready = 1;
    @(posedge clk); #1;
    rsp_ready = 0;
    send(3'b001, 4, 2, 5, 0, 16'h0);      take(32'h0100, 5, 0);
    send(3'b000, 1, 0, 1, 1, 16'd1);
    rst_n = 0;
    #1;
    chk("rst_exec_rsp_valid", {31'b0, rsp_valid}, 0);
    chk("rst_exec_cmd_ready", {31'b0, cmd_ready}, 1);
    chk("rst_exec_alu_A", alu_A, 0);
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;
    chk("after_rst_rsp_valid", {31'b0, rsp_valid}, 0);
    send(3'b000, 1, 0, 3, 1, 16'd0);      take(32'h0, 3, 0);
    send(3'b011, 4, 5, 6, 0, 16'h0);      take(32'h0, 6, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
